// File: rtl/speed_test_pkg.sv
// Shared types and constants for the ring-oscillator speed-test readout controller.
package speed_test_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RST     = 4'd1,
        ST_ARM     = 4'd2,
        ST_TRIG    = 4'd3,
        ST_SETTLE  = 4'd4,
        ST_RINGOFF = 4'd5,
        ST_READ    = 4'd6,
        ST_CHECK   = 4'd7,
        ST_FINISH  = 4'd8
    } state_e;

    localparam logic [2:0] SEL_STATUS   = 3'b111;
    localparam int         READ_BEATS   = 6;
    localparam int         ERR_TIMEOUT  = 0;
    localparam int         ERR_OVERFLOW = 1;
    localparam int         ERR_MISMATCH = 2;

    // Byte-select code for read beat idx; beats 0..2 are ring 0, 3..5 ring 1.
    function automatic logic [2:0] sel_for_idx(input logic [2:0] idx);
        logic [2:0] sel;
        case (idx)
            3'd0:    sel = 3'b000;
            3'd1:    sel = 3'b001;
            3'd2:    sel = 3'b010;
            3'd3:    sel = 3'b100;
            3'd4:    sel = 3'b101;
            3'd5:    sel = 3'b110;
            default: sel = SEL_STATUS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/speed_test_cnt_check.sv
// Combinational result checks: overflow (MSB cleared) and |count0-count1| above a limit.
module speed_test_cnt_check
    import speed_test_pkg::*;
#(
    parameter int MAX_DIFF = 3
) (
    input  logic [CNT_W-1:0] count0,
    input  logic [CNT_W-1:0] count1,
    output logic             overflow,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] MAX_DIFF_V = CNT_W'(MAX_DIFF);

    logic [CNT_W-1:0] diff_s;

    // Compare first so the subtraction never wraps.
    always_comb begin
        if (count0 >= count1) begin
            diff_s = count0 - count1;
        end else begin
            diff_s = count1 - count0;
        end
        overflow = ~count0[CNT_W-1] | ~count1[CNT_W-1];
        mismatch = (diff_s > MAX_DIFF_V);
    end

endmodule

// File: rtl/speed_test_readout_seq.sv
// Sequencer for the speed-test macro: reset, arm, trigger, wait for fired, read both counters.
module speed_test_readout_seq
    import speed_test_pkg::*;
#(
    parameter int TRIG_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int TIMEOUT       = 15,
    parameter int MAX_DIFF      = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [7:0]       meas_out,
    output logic             ctl_nrst,
    output logic             ctl_trig,
    output logic [2:0]       ctl_sel,
    output logic [1:0]       ctl_ring_en,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err
);

    localparam logic [4:0] TRIG_LAST = 5'(TRIG_CYCLES - 1);
    localparam logic [4:0] SETTLE_N  = 5'(SETTLE_CYCLES);
    localparam logic [4:0] WAIT_LAST = 5'(SETTLE_CYCLES + TIMEOUT - 1);
    localparam logic [4:0] READ_LAST = 5'(2 * READ_BEATS - 1);

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ctl_nrst_q, ctl_nrst_d;
    logic             ctl_trig_q, ctl_trig_d;
    logic [2:0]       ctl_sel_q, ctl_sel_d;
    logic [1:0]       ring_en_q, ring_en_d;
    logic [CNT_W-1:0] count0_q, count0_d;
    logic [CNT_W-1:0] count1_q, count1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       err_q, err_d;
    logic             overflow_s, mismatch_s;

    speed_test_cnt_check #(.MAX_DIFF(MAX_DIFF)) u_check (
        .count0   (count0_q),
        .count1   (count1_q),
        .overflow (overflow_s),
        .mismatch (mismatch_s)
    );

    // Next-state and registered-output values; outputs take the value of the state being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctl_nrst_d = ctl_nrst_q;
        ctl_trig_d = ctl_trig_q;
        ctl_sel_d  = ctl_sel_q;
        ring_en_d  = ring_en_q;
        count0_d   = count0_q;
        count1_d   = count1_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RST;
                    cnt_d      = 5'd0;
                    busy_d     = 1'b1;
                    err_d      = 3'b000;
                    ctl_nrst_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RST: begin
                state_d    = ST_ARM;
                cnt_d      = 5'd0;
                ctl_nrst_d = 1'b1;
                ctl_sel_d  = SEL_STATUS;
                ring_en_d  = 2'b11;
            end
            ST_ARM: begin
                if (cnt_q == 5'd0) begin
                    cnt_d = 5'd1;
                end else if (meas_out[6]) begin
                    // Fired before any trigger: the macro state cannot be trusted.
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d   = ST_FINISH;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ring_en_d = 2'b00;
                    ctl_sel_d = SEL_STATUS;
                end else begin
                    state_d    = ST_TRIG;
                    cnt_d      = 5'd0;
                    ctl_trig_d = 1'b1;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d    = ST_SETTLE;
                    cnt_d      = 5'd0;
                    ctl_trig_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q < SETTLE_N) begin
                    cnt_d = cnt_q + 5'd1;
                end else if (meas_out[6]) begin
                    state_d   = ST_RINGOFF;
                    cnt_d     = 5'd0;
                    ring_en_d = 2'b00;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d   = ST_FINISH;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    ring_en_d = 2'b00;
                    ctl_sel_d = SEL_STATUS;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_RINGOFF: begin
                state_d   = ST_READ;
                cnt_d     = 5'd0;
                ctl_sel_d = sel_for_idx(3'd0);
            end
            ST_READ: begin
                // cnt_q[0] is the beat phase (0: select driven, 1: capture), cnt_q[3:1] the beat.
                if (!cnt_q[0]) begin
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    case (cnt_q[3:1])
                        3'd0:    count0_d[7:0]   = meas_out;
                        3'd1:    count0_d[15:8]  = meas_out;
                        3'd2:    count0_d[23:16] = meas_out;
                        3'd3:    count1_d[7:0]   = meas_out;
                        3'd4:    count1_d[15:8]  = meas_out;
                        3'd5:    count1_d[23:16] = meas_out;
                        default: count0_d        = count0_q;
                    endcase
                    if (cnt_q == READ_LAST) begin
                        state_d = ST_CHECK;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d     = cnt_q + 5'd1;
                        ctl_sel_d = sel_for_idx(cnt_q[3:1] + 3'd1);
                    end
                end
            end
            ST_CHECK: begin
                err_d[ERR_OVERFLOW] = overflow_s;
                err_d[ERR_MISMATCH] = mismatch_s;
                state_d   = ST_FINISH;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                ring_en_d = 2'b00;
                ctl_sel_d = SEL_STATUS;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            ctl_nrst_q <= 1'b0;
            ctl_trig_q <= 1'b0;
            ctl_sel_q  <= 3'b000;
            ring_en_q  <= 2'b00;
            count0_q   <= '0;
            count1_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctl_nrst_q <= ctl_nrst_d;
            ctl_trig_q <= ctl_trig_d;
            ctl_sel_q  <= ctl_sel_d;
            ring_en_q  <= ring_en_d;
            count0_q   <= count0_d;
            count1_q   <= count1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ctl_nrst    = ctl_nrst_q;
    assign ctl_trig    = ctl_trig_q;
    assign ctl_sel     = ctl_sel_q;
    assign ctl_ring_en = ring_en_q;
    assign count0      = count0_q;
    assign count1      = count1_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_speed_test_readout_seq.sv
// Scoreboard bench for speed_test_readout_seq with a behavioural speed-test macro model.
module tb_speed_test_readout_seq;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [7:0]  meas_out;
    logic        ctl_nrst, ctl_trig;
    logic [2:0]  ctl_sel;
    logic [1:0]  ctl_ring_en;
    logic [23:0] count0, count1;
    logic        busy, done;
    logic [2:0]  err;

    always #5 clk = ~clk;

    speed_test_readout_seq dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .meas_out    (meas_out),
        .ctl_nrst    (ctl_nrst),
        .ctl_trig    (ctl_trig),
        .ctl_sel     (ctl_sel),
        .ctl_ring_en (ctl_ring_en),
        .count0      (count0),
        .count1      (count1),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Macro model: fired rises fire_n clocks after trig is first seen (fire_n == 0: never).
    logic [23:0] m_c0, m_c1;
    int          fire_n;
    logic        m_fired;
    int          m_tcnt;

    always @(posedge clk) begin
        if (!ctl_nrst) begin
            m_fired <= 1'b0;
            m_tcnt  <= 0;
        end else if (ctl_trig || m_tcnt != 0) begin
            m_tcnt <= m_tcnt + 1;
            if (fire_n != 0 && m_tcnt + 1 >= fire_n) m_fired <= 1'b1;
        end
    end

    always_comb begin
        meas_out = 8'h00;
        case (ctl_sel)
            3'b000:  meas_out = m_c0[7:0];
            3'b001:  meas_out = m_c0[15:8];
            3'b010:  meas_out = m_c0[23:16];
            3'b100:  meas_out = m_c1[7:0];
            3'b101:  meas_out = m_c1[15:8];
            3'b110:  meas_out = m_c1[23:16];
            3'b111:  meas_out = {1'b0, m_fired, 6'b000000};
            default: meas_out = 8'h00;
        endcase
    end

    typedef struct packed {
        logic [23:0] c0;
        logic [23:0] c1;
        logic [2:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    logic [2:0]  sel_q[$];
    logic [2:0]  sel_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [2:0]  prev_sel = 3'b000;
    logic [23:0] last_c0 = 24'h0;
    logic [23:0] last_c1 = 24'h0;
    exp_t        mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pops expected results on done and expected select codes on each new read select.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("count0", count0, mon_e.c0);
                chk("count1", count1, mon_e.c1);
                chk("err", err, mon_e.err);
            end
        end
        if (nrst === 1'b1 && busy === 1'b1 && ctl_sel != prev_sel && ctl_sel != 3'b111) begin
            chk("sel_expected", sel_q.size() != 0, 1);
            if (sel_q.size() != 0) chk("sel_seq", ctl_sel, sel_q.pop_front());
        end
        prev_sel = ctl_sel;
    end

    task automatic chk_reset();
        chk("rst_ctl_nrst", ctl_nrst, 0);
        chk("rst_trig", ctl_trig, 0);
        chk("rst_sel", ctl_sel, 0);
        chk("rst_ring_en", ctl_ring_en, 0);
        chk("rst_count0", count0, 0);
        chk("rst_count1", count1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic run_meas(input logic [23:0] c0, input logic [23:0] c1, input int fn,
                            input logic [2:0] exp_err, input int exp_lat, input bit extra_start);
        int lat;
        int d0;
        m_c0   = c0;
        m_c1   = c1;
        fire_n = fn;
        if (fn != 0) begin
            last_c0 = c0;
            last_c1 = c1;
            for (int i = 0; i < 6; i++) sel_q.push_back(sel_tab[i]);
        end
        exp_q.push_back('{c0: last_c0, c1: last_c1, err: exp_err});
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        chk("busy_on_start", busy, 1);
        chk("err_cleared", err, 0);
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (extra_start && lat == 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("latency", lat, exp_lat);
        chk("busy_at_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("err_held", err, exp_err);
        chk("single_done", done_cnt - d0, 1);
    endtask

    initial begin
        nrst   = 1'b1;
        start  = 1'b0;
        m_c0   = 24'h0;
        m_c1   = 24'h0;
        fire_n = 5;
        #2 nrst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        nrst = 1'b1;
        @(negedge clk);

        run_meas(24'hFFF000, 24'hFFF002, 5, 3'b000, 23, 1'b0);
        run_meas(24'hFFF000, 24'hFFF010, 8, 3'b100, 26, 1'b0);
        run_meas(24'hFFF010, 24'hFFF000, 5, 3'b100, 23, 1'b0);
        run_meas(24'hFFF000, 24'hFFF003, 5, 3'b000, 23, 1'b0);
        run_meas(24'hFEDCBA, 24'hFEDCBA, 5, 3'b000, 23, 1'b0);
        run_meas(24'h7FFFF0, 24'h7FFFF1, 5, 3'b010, 23, 1'b0);
        run_meas(24'h800000, 24'h800002, 5, 3'b000, 23, 1'b0);
        run_meas(24'h7FFFFF, 24'hFFFFFF, 5, 3'b110, 23, 1'b0);
        run_meas(24'h123456, 24'h654321, 0, 3'b001, 23, 1'b0);

        // Reset during read beat 3: everything back to reset values.
        m_c0   = 24'hFFF000;
        m_c1   = 24'hFFF001;
        fire_n = 5;
        for (int i = 0; i < 6; i++) sel_q.push_back(sel_tab[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 nrst = 1'b0;
        #1 chk_reset();
        sel_q.delete();
        last_c0 = 24'h0;
        last_c1 = 24'h0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk_reset();

        run_meas(24'hFFF000, 24'hFFF001, 5, 3'b000, 23, 1'b0);
        run_meas(24'hFFF100, 24'hFFF0FF, 5, 3'b000, 23, 1'b1);

        repeat (5) @(negedge clk);
        chk("sel_q_empty", sel_q.size(), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
